karatsuba_seq_ctrl: RTL and testbench



---
 rtl/kseq_pkg.sv | 28 ++
 rtl/karatsuba_mul_core.sv | 13 +
 rtl/karatsuba_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_karatsuba_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/kseq_pkg.sv
// Shared definitions for the Karatsuba sequential multiplier controller:
// FSM state encoding and the width-derivation helpers H, MW and PW.
package kseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_LO  = 3'd1,
        ST_MUL_HI  = 3'd2,
        ST_MUL_MID = 3'd3,
        ST_DONE    = 3'd4
    } kseq_state_e;

    // Half operand width.
    function automatic int unsigned kseq_h(input int unsigned w);
        return w / 2;
    endfunction

    // Shared multiplier operand width; one extra bit holds the carry of xh+xl.
    function automatic int unsigned kseq_mw(input int unsigned w);
        return (w / 2) + 1;
    endfunction

    // Full product width.
    function automatic int unsigned kseq_pw(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/karatsuba_mul_core.sv
// Combinational unsigned MW x MW -> 2*MW multiplier shared by all three
// Karatsuba sub-products.
module karatsuba_mul_core #(
    parameter int unsigned MW = 5
) (
    input  logic [MW-1:0]   a,
    input  logic [MW-1:0]   b,
    output logic [2*MW-1:0] p
);

    assign p = (2*MW)'(a) * (2*MW)'(b);

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential W x W Karatsuba multiplier: three sub-products on one shared
// (W/2+1)-bit multiplier. Optional KSEQ_ZERO_BYPASS_EN skips the multiplies
// when either operand is zero.
module karatsuba_seq_ctrl
    import kseq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           busy
);

    localparam int unsigned H  = kseq_h(W);
    localparam int unsigned MW = kseq_mw(W);
    localparam int unsigned PW = kseq_pw(W);

    kseq_state_e state;

    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [PW-1:0]   z0;
    logic [PW-1:0]   z2;
`ifdef KSEQ_ZERO_BYPASS_EN
    logic            zero_r;
`endif

    logic [H-1:0]    xh;
    logic [H-1:0]    xl;
    logic [H-1:0]    yh;
    logic [H-1:0]    yl;
    logic [MW-1:0]   mul_a;
    logic [MW-1:0]   mul_b;
    logic [2*MW-1:0] mul_p;
    logic [PW-1:0]   mid;
    logic [PW-1:0]   z1;
    logic [PW-1:0]   prod_sum;

    assign xh = x_r[W-1:H];
    assign xl = x_r[H-1:0];
    assign yh = y_r[W-1:H];
    assign yl = y_r[H-1:0];

    // Operand mux feeding the shared multiplier, one sub-product per state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_MUL_LO: begin
                mul_a = MW'(xl);
                mul_b = MW'(yl);
            end
            ST_MUL_HI: begin
                mul_a = MW'(xh);
                mul_b = MW'(yh);
            end
            ST_MUL_MID: begin
                mul_a = MW'(xh) + MW'(xl);
                mul_b = MW'(yh) + MW'(yl);
            end
            default: ;
        endcase
`ifdef KSEQ_ZERO_BYPASS_EN
        if (zero_r) begin
            mul_a = '0;
            mul_b = '0;
        end
`endif
    end

    karatsuba_mul_core #(
        .MW (MW)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Recombination; z1 cannot underflow since mid >= z2 + z0.
    assign mid      = PW'(mul_p);
    assign z1       = mid - z2 - z0;
    assign prod_sum = (z2 << W) + (z1 << H) + z0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_r       <= '0;
            y_r       <= '0;
            z0        <= '0;
            z2        <= '0;
            out_prod  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef KSEQ_ZERO_BYPASS_EN
            zero_r    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_r      <= in_x;
                        y_r      <= in_y;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_MUL_LO;
`ifdef KSEQ_ZERO_BYPASS_EN
                        zero_r   <= (in_x == '0) || (in_y == '0);
`endif
                    end
                end
                ST_MUL_LO: begin
`ifdef KSEQ_ZERO_BYPASS_EN
                    if (zero_r) begin
                        out_prod  <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        z0    <= mid;
                        state <= ST_MUL_HI;
                    end
`else
                    z0    <= mid;
                    state <= ST_MUL_HI;
`endif
                end
                ST_MUL_HI: begin
                    z2    <= mid;
                    state <= ST_MUL_MID;
                end
                ST_MUL_MID: begin
                    out_prod  <= prod_sum;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Result held stable until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
`ifdef KSEQ_ZERO_BYPASS_EN
                        zero_r    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench for karatsuba_seq_ctrl (W=8 and W=4 instances),
// reference products computed as plain x*y; honours KSEQ_ZERO_BYPASS_EN.
module tb_karatsuba_seq_ctrl;

`ifdef KSEQ_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  in_x8, in_y8;
    logic [15:0] out_prod8;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  in_x4, in_y4;
    logic [7:0]  out_prod4;

    logic        sel;
    logic        rdy_m, ov_m, busy_m;
    logic [15:0] prod_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    karatsuba_seq_ctrl #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_x(in_x8), .in_y(in_y8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_prod(out_prod8), .busy(busy8)
    );

    karatsuba_seq_ctrl #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_x(in_x4), .in_y(in_y4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_prod(out_prod4), .busy(busy4)
    );

    assign rdy_m  = sel ? in_ready4  : in_ready8;
    assign ov_m   = sel ? out_valid4 : out_valid8;
    assign busy_m = sel ? busy4      : busy8;
    assign prod_m = sel ? {8'h00, out_prod4} : out_prod8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_xy(input logic [7:0] x, input logic [7:0] y);
        if (sel) begin
            in_x4 = x[3:0];
            in_y4 = y[3:0];
        end else begin
            in_x8 = x;
            in_y8 = y;
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) in_valid4 = v; else in_valid8 = v;
    endtask

    task automatic set_oready(input logic r);
        if (sel) out_ready4 = r; else out_ready8 = r;
    endtask

    // One operation: stall<0 means out_ready held high in advance.
    task automatic do_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                         input int stall, input bit hold_valid, input int exp_lat);
        logic [15:0] exp_p;
        logic [15:0] held;
        int lat;
        exp_p = 16'(x) * 16'(y);
        @(negedge clk);
        sel = s;
        drive_xy(x, y);
        set_valid(1'b1);
        set_oready(stall < 0);
        #1;
        chk("in_ready_idle", 32'(rdy_m), 32'd1);
        @(posedge clk); #1;
        if (!hold_valid) set_valid(1'b0);
        drive_xy(8'($urandom), 8'($urandom));
        chk("busy_after_accept", 32'(busy_m), 32'd1);
        chk("in_ready_after_accept", 32'(rdy_m), 32'd0);
        lat = 0;
        while (!ov_m && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (hold_valid) begin
                chk("in_ready_held_low", 32'(rdy_m), 32'd0);
                drive_xy(8'($urandom), 8'($urandom));
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("product", 32'(prod_m), 32'(exp_p));
        held = prod_m;
        if (stall >= 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk("valid_during_stall", 32'(ov_m), 32'd1);
                chk("prod_stable", 32'(prod_m), 32'(held));
                chk("in_ready_during_stall", 32'(rdy_m), 32'd0);
            end
            set_oready(1'b1);
        end
        @(posedge clk); #1;
        set_valid(1'b0);
        set_oready(1'b0);
        chk("valid_after_handshake", 32'(ov_m), 32'd0);
        chk("in_ready_after_handshake", 32'(rdy_m), 32'd1);
        chk("busy_after_handshake", 32'(busy_m), 32'd0);
    endtask

    initial begin
        logic [7:0] rx, ry;
        int         st;
        rst = 1'b1;
        sel = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; in_x8 = '0; in_y8 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_x4 = '0; in_y4 = '0;
        #3;
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_prod8", 32'(out_prod8), 32'd0);
        chk("rst_in_ready4", 32'(in_ready4), 32'd1);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 8'h12, 8'h34, -1, 1'b0, 3);
        do_op(1'b0, 8'hFF, 8'hFF, 2, 1'b0, 3);
        do_op(1'b0, 8'h21, 8'h13, 1, 1'b1, 3);
        do_op(1'b0, 8'h00, 8'hAB, -1, 1'b0, ZLAT);
        do_op(1'b0, 8'hCD, 8'h00, 1, 1'b0, ZLAT);

        for (int n = 0; n < 24; n++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rx = 8'h00;
            st = int'($urandom_range(0, 3)) - 1;
            do_op(1'b0, rx, ry, st, 1'b0, (rx == 8'h00 || ry == 8'h00) ? ZLAT : 3);
        end

        // Reset pulse while in MUL_HI aborts the operation.
        @(negedge clk);
        sel = 1'b0;
        in_x8 = 8'h55; in_y8 = 8'h66; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready8), 32'd1);
        chk("abort_out_valid", 32'(out_valid8), 32'd0);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_prod", 32'(out_prod8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_valid_after_abort", 32'(out_valid8), 32'd0);
        end
        do_op(1'b0, 8'h03, 8'h05, -1, 1'b0, 3);

        // W=4 exhaustive sweep with random backpressure.
        for (int i = 0; i < 256; i++) begin
            rx = 8'(i / 16);
            ry = 8'(i % 16);
            st = int'($urandom_range(0, 3)) - 1;
            do_op(1'b1, rx, ry, st, 1'b0, (rx == 8'h00 || ry == 8'h00) ? ZLAT : 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
